oam_dma_controller: RTL and testbench

- Sprite DMA engine and bus arbiter for the CPU core.
- A CPU write to $4014 makes the block stall the CPU register file, take the shared address/data bus, and copy 256 bytes from page $XX00–$XXFF to the PPU OAM data port $2004.
- Returns the bus to the CPU on completion.
- Sits between the CPU core (drives its `stall`) and the top-level bus mux (drives `bus_sel`).

---
 rtl/oam_dma_controller_if.sv | 33 +++
 rtl/oam_dma_controller.sv | 104 ++++++++++
 tb/tb_oam_dma_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_controller_if.sv
// CPU/DMA bus bundle for the OAM sprite DMA controller.
// With DMC_DMA_EN defined it also carries the DMC sample-fetch request/ack.
interface oam_dma_controller_if;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic [7:0]  mem_rdata;
   logic        stall;
   logic        bus_sel;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic        dma_wr;
   logic [7:0]  dma_wdata;
   logic        busy;
`ifdef DMC_DMA_EN
   logic        dmc_req;
   logic [15:0] dmc_addr;
   logic [7:0]  dmc_data;
   logic        dmc_ack;

   modport master (input cpu_addr, cpu_we, cpu_wdata, mem_rdata, dmc_req, dmc_addr,
                   output stall, bus_sel, dma_addr, dma_rd, dma_wr, dma_wdata, busy,
                   dmc_data, dmc_ack);
   modport slave  (output cpu_addr, cpu_we, cpu_wdata, mem_rdata, dmc_req, dmc_addr,
                   input stall, bus_sel, dma_addr, dma_rd, dma_wr, dma_wdata, busy,
                   dmc_data, dmc_ack);
`else
   modport master (input cpu_addr, cpu_we, cpu_wdata, mem_rdata,
                   output stall, bus_sel, dma_addr, dma_rd, dma_wr, dma_wdata, busy);
   modport slave  (output cpu_addr, cpu_we, cpu_wdata, mem_rdata,
                   input stall, bus_sel, dma_addr, dma_rd, dma_wr, dma_wdata, busy);
`endif
endinterface

// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: a CPU write to TRIGGER_ADDR stalls the CPU and copies page $XX00-$XXFF to OAM_PORT.
// Optional DMC_DMA_EN adds DMC sample fetches that steal read slots (requester drops dmc_req on dmc_ack).
module oam_dma_controller #(
   parameter logic [15:0] OAM_PORT     = 16'h2004,
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014
) (
   input logic clk,
   input logic rst,
   oam_dma_controller_if.master bus
);
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DUMMY, DMC_READ} state_t;

   state_t      state, state_nx;
   logic        parity;
   logic [7:0]  page, idx, buf_q;
   logic        trig, oam_on, dmc_pend;
   logic        stall;
   logic [15:0] dma_addr;

   assign trig = (state == IDLE) && bus.cpu_we && (bus.cpu_addr == TRIGGER_ADDR);

`ifdef DMC_DMA_EN
   logic oam_act;
   assign oam_on   = oam_act;
   assign dmc_pend = bus.dmc_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  oam_act <= 1'b0;
      else if (trig)                            oam_act <= 1'b1;
      else if (state == WRITE && idx == 8'hFF)  oam_act <= 1'b0;
   end

   assign bus.dmc_ack  = (state == DMC_READ);
   assign bus.dmc_data = bus.mem_rdata;
`else
   assign oam_on   = 1'b1;
   assign dmc_pend = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         parity <= 1'b0;
         page   <= 8'h00;
         idx    <= 8'h00;
         buf_q  <= 8'h00;
      end else begin
         state  <= state_nx;
         parity <= ~parity;
         if (trig) begin
            page <= bus.cpu_wdata;
            idx  <= 8'h00;
         end
         if (state == READ)  buf_q <= bus.mem_rdata;
         if (state == WRITE) idx   <= idx + 8'd1;
      end
   end

   // Reads must land on parity-0 cycles; HALT/DUMMY insert ALIGN when the next cycle would be odd.
   always_comb begin
      state_nx = state;
      dma_addr = 16'h0000;
      unique case (state)
         IDLE:  if (trig || dmc_pend) state_nx = HALT;
         HALT: begin
            if (dmc_pend)    state_nx = DUMMY;
            else if (oam_on) state_nx = parity ? READ : ALIGN;
            else             state_nx = IDLE;
         end
         ALIGN: begin
            if (dmc_pend)    state_nx = DMC_READ;
            else if (oam_on) state_nx = READ;
            else             state_nx = IDLE;
         end
         READ: begin
            dma_addr = {page, idx};
            state_nx = WRITE;
         end
         WRITE: begin
            dma_addr = OAM_PORT;
            if (idx == 8'hFF)  state_nx = IDLE;
            else if (dmc_pend) state_nx = DMC_READ;
            else               state_nx = READ;
         end
`ifdef DMC_DMA_EN
         DUMMY:    state_nx = parity ? DMC_READ : ALIGN;
         DMC_READ: begin
            dma_addr = bus.dmc_addr;
            state_nx = oam_on ? ALIGN : IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   assign stall         = (state != IDLE);
   assign bus.stall     = stall;
   assign bus.busy      = stall;
   assign bus.bus_sel   = stall;
   assign bus.dma_addr  = dma_addr;
   assign bus.dma_rd    = (state == READ) || (state == DMC_READ);
   assign bus.dma_wr    = (state == WRITE);
   assign bus.dma_wdata = buf_q;
endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: scoreboard of expected read addresses and OAM write data.
module tb_oam_dma_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic par;
   logic inv_pat = 1'b0;
   int   vecs = 0;
   int   errs = 0;
   logic [15:0] exp_addr[$];
   logic [7:0]  exp_data[$];

   oam_dma_controller_if bus();

   oam_dma_controller #(.OAM_PORT(16'h2004), .TRIGGER_ADDR(16'h4014)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference cycle parity: cleared by reset, toggles on every edge otherwise.
   always @(posedge clk or posedge rst)
      if (rst) par <= 1'b0;
      else     par <= ~par;

   function automatic logic [7:0] pat(input logic [15:0] a, input logic inv);
      return inv ? ~a[7:0] : (a[7:0] ^ a[15:8] ^ 8'h3C);
   endfunction

   assign bus.mem_rdata = pat(bus.dma_addr, inv_pat);

   task automatic test_reset();
      bus.cpu_addr = 16'h0; bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h0;
`ifdef DMC_DMA_EN
      bus.dmc_req = 1'b0; bus.dmc_addr = 16'hC000;
`endif
      rst = 1'b1;
      #2;
      vecs++;
      if ({bus.stall, bus.bus_sel, bus.busy, bus.dma_rd, bus.dma_wr, bus.dma_addr, bus.dma_wdata} !== 29'd0) begin
         errs++;
         $display("FAIL reset_outputs: got stall=%b bus_sel=%b busy=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                  bus.stall, bus.bus_sel, bus.busy, bus.dma_rd, bus.dma_wr, bus.dma_addr, bus.dma_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_nontrigger();
      logic [15:0] a [3] = '{16'h4015, 16'h2004, 16'h4014};
      logic        w [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.cpu_addr = a[i]; bus.cpu_we = w[i]; bus.cpu_wdata = 8'h02;
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.cpu_we = 1'b0;
            vecs++;
            if ({bus.stall, bus.bus_sel, bus.dma_rd, bus.dma_wr} !== 4'b0) begin
               errs++;
               $display("FAIL nontrigger_%h_we%0d: got stall=%b bus_sel=%b rd=%b wr=%b, want 0",
                        a[i], w[i], bus.stall, bus.bus_sel, bus.dma_rd, bus.dma_wr);
            end
         end
      end
      bus.cpu_addr = 16'h0;
   endtask

   // Drives one trigger and follows the whole transfer; abort_at>0 pulses reset during that write number.
   task automatic run_dma(input logic [7:0] page, input bit odd, input int abort_at,
                          input int dmc_idx, input int exp_stall, input string name);
      int stall_cnt = 0;
      int wcnt = 0;
      int cyc = 0;
      int dmc_seen = 0;
      bit is_dmc;
      bit aborted = 0;
      @(negedge clk);
      while (par !== (odd ? 1'b0 : 1'b1)) @(negedge clk);
      bus.cpu_we = 1'b1; bus.cpu_addr = 16'h4014; bus.cpu_wdata = page;
      exp_addr.delete(); exp_data.delete();
      for (int i = 0; i < 256; i++) begin
         exp_addr.push_back({page, i[7:0]});
         exp_data.push_back(pat({page, i[7:0]}, inv_pat));
      end
      #1;
      vecs++;
      if (bus.stall !== 1'b0) begin
         errs++; $display("FAIL %s_trigger_cycle: stall=%b, want 0", name, bus.stall);
      end
      @(negedge clk);
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0;
      vecs++;
      if (bus.stall !== 1'b1) begin
         errs++; $display("FAIL %s_stall_latency: stall=%b, want 1", name, bus.stall);
      end
      while (bus.stall === 1'b1 && cyc < 700) begin
         stall_cnt++; cyc++;
         is_dmc = 1'b0;
`ifdef DMC_DMA_EN
         if (bus.dmc_ack === 1'b1) begin
            is_dmc = 1'b1; dmc_seen++;
            vecs += 2;
            if (bus.dma_addr !== 16'hC000 || bus.dma_rd !== 1'b1) begin
               errs++; $display("FAIL %s_dmc_addr: addr=%h rd=%b, want C000 1", name, bus.dma_addr, bus.dma_rd);
            end
            if (bus.dmc_data !== pat(16'hC000, inv_pat)) begin
               errs++; $display("FAIL %s_dmc_data: got %h, want %h", name, bus.dmc_data, pat(16'hC000, inv_pat));
            end
            bus.dmc_req = 1'b0;
         end
`endif
         if (bus.dma_rd === 1'b1 && !is_dmc) begin
            vecs += 2;
            if (exp_addr.size() == 0 || bus.dma_addr !== exp_addr[0]) begin
               errs++; $display("FAIL %s_read_addr: got %h, want %h", name, bus.dma_addr,
                                (exp_addr.size() > 0) ? exp_addr[0] : 16'hxxxx);
            end
            if (par !== 1'b0) begin
               errs++; $display("FAIL %s_read_parity: parity=%b, want 0", name, par);
            end
         end
         if (bus.dma_wr === 1'b1) begin
            vecs += 2;
            if (bus.dma_addr !== 16'h2004) begin
               errs++; $display("FAIL %s_write_addr: got %h, want 2004", name, bus.dma_addr);
            end
            if (exp_data.size() == 0 || bus.dma_wdata !== exp_data[0]) begin
               errs++; $display("FAIL %s_write_data #%0d: got %h, want %h", name, wcnt, bus.dma_wdata,
                                (exp_data.size() > 0) ? exp_data[0] : 8'hxx);
            end
            if (exp_data.size() > 0) begin
               void'(exp_data.pop_front()); void'(exp_addr.pop_front());
            end
            wcnt++;
            if (abort_at > 0 && wcnt == abort_at) begin
               rst = 1'b1;
               #1;
               vecs++;
               if ({bus.stall, bus.bus_sel, bus.busy, bus.dma_rd, bus.dma_wr} !== 5'b0) begin
                  errs++; $display("FAIL %s_abort: stall=%b bus_sel=%b busy=%b rd=%b wr=%b, want 0",
                                   name, bus.stall, bus.bus_sel, bus.busy, bus.dma_rd, bus.dma_wr);
               end
               aborted = 1'b1;
               break;
            end
`ifdef DMC_DMA_EN
            if (dmc_idx > 0 && wcnt == dmc_idx) bus.dmc_req = 1'b1;
`endif
         end
         @(negedge clk);
      end
      if (aborted) begin
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      vecs++;
      if (cyc >= 700) begin
         errs++; $display("FAIL %s_timeout: stall still %b after %0d cycles, want release", name, bus.stall, cyc);
      end else if (stall_cnt != exp_stall) begin
         errs++; $display("FAIL %s_stall_len: got %0d, want %0d", name, stall_cnt, exp_stall);
      end
      vecs += 2;
      if (wcnt != 256 || exp_data.size() != 0) begin
         errs++; $display("FAIL %s_write_count: got %0d writes (%0d left), want 256 (0 left)", name, wcnt, exp_data.size());
      end
      if ({bus.bus_sel, bus.busy, bus.dma_rd, bus.dma_wr} !== 4'b0) begin
         errs++; $display("FAIL %s_release: bus_sel=%b busy=%b rd=%b wr=%b, want 0",
                          name, bus.bus_sel, bus.busy, bus.dma_rd, bus.dma_wr);
      end
      if (dmc_idx > 0) begin
         vecs++;
         if (dmc_seen != 1) begin
            errs++; $display("FAIL %s_dmc_count: got %0d acks, want 1", name, dmc_seen);
         end
      end
   endtask

   task automatic test_odd_parity();  inv_pat = 1'b0; run_dma(8'h02, 1'b1, 0, 0, 513, "odd");  endtask
   task automatic test_even_parity(); inv_pat = 1'b0; run_dma(8'h02, 1'b0, 0, 0, 514, "even"); endtask
   task automatic test_page_ff();     inv_pat = 1'b1; run_dma(8'hFF, 1'b1, 0, 0, 513, "pageff"); endtask

   task automatic test_reset_mid();
      inv_pat = 1'b0;
      run_dma(8'h02, 1'b1, 100, 0, 0, "abort");
      run_dma(8'h02, 1'b1, 0, 0, 513, "after_abort");
   endtask

`ifdef DMC_DMA_EN
   task automatic test_dmc();
      inv_pat = 1'b0;
      run_dma(8'h03, 1'b1, 0, 10, 515, "dmc");
   endtask
`endif

   initial begin
      test_reset();
      test_nontrigger();
      test_odd_parity();
      test_even_parity();
      test_page_ff();
      test_reset_mid();
`ifdef DMC_DMA_EN
      test_dmc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
